// File: rtl/latency_pop_adapter_if.sv
// Source-side pop/data and consumer-side valid/ready signals of latency_pop_adapter.
// slave is the adapter's view; master is the view of whatever drives it.
interface latency_pop_adapter_if #(
    parameter int WIDTH = 8
);
    logic             src_may_pop;
    logic             src_pop;
    logic [WIDTH-1:0] src_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport slave (
        input  src_may_pop, src_data, out_ready,
        output src_pop, out_valid, out_data
    );

    modport master (
        output src_may_pop, src_data, out_ready,
        input  src_pop, out_valid, out_data
    );
endinterface

// File: rtl/latency_pop_adapter.sv
// Turns a fixed-latency pop source into a valid/ready stream using credit-limited pops.
// Optional macro LATENCY_POP_ADAPTER_STATS_EN adds saturating beat/stall counters.
module latency_pop_adapter #(
    parameter int WIDTH     = 8,
    parameter int LATENCY   = 2,
    parameter int BUF_DEPTH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    latency_pop_adapter_if.slave bus
`ifdef LATENCY_POP_ADAPTER_STATS_EN
    ,
    output logic [31:0]          stat_beats,
    output logic [31:0]          stat_stalls
`endif
);
    localparam int OW = $clog2(BUF_DEPTH + 1);
    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = $clog2(BUF_DEPTH + LATENCY + 1) + 1;

    logic [LATENCY-1:0] pipe_q, pipe_d;
    logic [OW-1:0]      occ_q, occ_d;
    logic [PW-1:0]      head_q, head_d, tail_q, tail_d;
    logic [WIDTH-1:0]   mem_q [BUF_DEPTH];
    logic [CW-1:0]      inflight, used;
    logic               out_vld, deq, cap, pop;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LATENCY; i++) inflight = inflight + CW'(pipe_q[i]);
    end

    assign out_vld = (occ_q != '0);
    assign deq     = out_vld && bus.out_ready;
    assign cap     = pipe_q[LATENCY-1];
    // Every buffered or returning word holds a slot; a slot freed this cycle is reusable now.
    assign used    = CW'(occ_q) + inflight - CW'(deq);
    assign pop     = !rst && bus.src_may_pop && (used < CW'(BUF_DEPTH));

    always_comb begin
        pipe_d    = '0;
        pipe_d[0] = pop;
        for (int i = 1; i < LATENCY; i++) pipe_d[i] = pipe_q[i-1];
        head_d = deq ? wrap_inc(head_q) : head_q;
        tail_d = cap ? wrap_inc(tail_q) : tail_q;
        occ_d  = occ_q + OW'(cap) - OW'(deq);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_q <= '0;
            occ_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            pipe_q <= pipe_d;
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
            if (cap) mem_q[tail_q] <= bus.src_data;
        end
    end

    assign bus.src_pop   = pop;
    assign bus.out_valid = out_vld;
    assign bus.out_data  = mem_q[head_q];

`ifdef LATENCY_POP_ADAPTER_STATS_EN
    logic [31:0] beats_q, stalls_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            beats_q  <= '0;
            stalls_q <= '0;
        end else begin
            if (deq && beats_q != '1) beats_q <= beats_q + 32'd1;
            if (out_vld && !bus.out_ready && stalls_q != '1) stalls_q <= stalls_q + 32'd1;
        end
    end

    assign stat_beats  = beats_q;
    assign stat_stalls = stalls_q;
`endif
endmodule
